// File: rtl/pwm_ctrl_pkg.sv
// Shared encodings and helpers for the PWM soft-start sequencer.
// Cooldown length is used only when PWM_SOFTSTART_AUTO_RETRY_EN is defined.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  localparam int         COOL_W       = 24;
  localparam logic [COOL_W-1:0] COOLDOWN_LEN = 24'h10_0000;

  // Saturating move of cur toward tgt by at most step, 9-bit math
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] s;
    logic [DUTY_W-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, step};
    r = cur;
    if (c < t) begin
      r = ((t - c) <= s) ? tgt : DUTY_W'(c + s);
    end else if (c > t) begin
      r = ((c - t) <= s) ? tgt : DUTY_W'(c - s);
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_softstart_ctrl_ramp_tick_gen.sv
// Ramp prescaler: counts 0..DIV-1 and pulses tick on the wrap cycle.
// Synchronous clear restarts the count at 0.
module ramp_tick_gen #(
  parameter int DIV = 256
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_softstart_ctrl.sv
// Soft-start / ramp-down / fault sequencer for the 8-bit ZVS PWM generator.
// Define PWM_SOFTSTART_AUTO_RETRY_EN for timed auto-exit from FAULT.
module pwm_softstart_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_DIV  = 256,
  parameter int RAMP_STEP = 1,
  parameter int MAX_DUTY  = 240
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              pwm_reset,
  output logic              running,
  output logic              fault_latched,
  output logic [2:0]        state
);

  localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] STEP  = DUTY_W'(RAMP_STEP);

  logic [2:0]        state_q;
  logic [2:0]        state_nx;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_nx;
  logic [DUTY_W-1:0] tgt;
  logic              pwm_reset_q;
  logic              running_q;
  logic              fault_q;
  logic              tick;
  logic              tick_clr;
  logic              cool_done;

  assign tgt = (target_duty > MAX_D) ? MAX_D : target_duty;

  // Ramp states restart the prescaler so the first step is a full period out
  assign tick_clr = (state_nx != state_q) &&
                    ((state_nx == ST_RAMP_UP) ||
                     (state_nx == ST_RAMP_DOWN));

  ramp_tick_gen #(
    .DIV (RAMP_DIV)
  ) u_tick (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

`ifdef PWM_SOFTSTART_AUTO_RETRY_EN
  logic [COOL_W-1:0] cool_q;

  assign cool_done = (cool_q == COOLDOWN_LEN - 24'd1);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cool_q <= '0;
    end else if (state_q != ST_FAULT || fault || cool_done) begin
      cool_q <= '0;
    end else begin
      cool_q <= cool_q + 24'd1;
    end
  end
`else
  assign cool_done = 1'b0;
`endif

  always_comb begin
    state_nx = state_q;
    duty_nx  = duty_q;
    case (state_q)
      ST_IDLE: begin
        duty_nx = '0;
        if (enable) state_nx = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!enable) begin
          state_nx = ST_RAMP_DOWN;
        end else if (duty_q == tgt) begin
          state_nx = ST_RUN;
        end else if (tick) begin
          duty_nx = step_toward(duty_q, tgt, STEP);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nx = ST_RAMP_DOWN;
        end else if (tick) begin
          duty_nx = step_toward(duty_q, tgt, STEP);
        end
      end
      ST_RAMP_DOWN: begin
        if (enable) begin
          state_nx = ST_RAMP_UP;
        end else if (duty_q == '0) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          duty_nx = step_toward(duty_q, '0, STEP);
        end
      end
      ST_FAULT: begin
        duty_nx = '0;
        if ((fault_clr && !fault) || cool_done) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        duty_nx  = '0;
      end
    endcase
    if (fault) begin
      state_nx = ST_FAULT;
      duty_nx  = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      pwm_reset_q <= 1'b1;
      running_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_nx;
      duty_q      <= duty_nx;
      pwm_reset_q <= (state_nx == ST_IDLE) ||
                     (state_nx == ST_FAULT);
      running_q   <= (state_nx == ST_RUN);
      fault_q     <= (state_nx == ST_FAULT);
    end
  end

  assign duty_cycle    = duty_q;
  assign pwm_reset     = pwm_reset_q;
  assign running       = running_q;
  assign fault_latched = fault_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pwm_softstart_ctrl.sv
// Self-checking bench for pwm_softstart_ctrl (RAMP_DIV=4, RAMP_STEP=16).
// Table-driven vectors plus hand sequences for fault and async reset.
module tb_pwm_softstart_ctrl;

  typedef struct packed {
    logic [7:0] duty;
    logic       pr;
    logic       rn;
    logic       fl;
    logic [2:0] st;
  } out_t;

  typedef struct {
    string      nm;
    logic       en;
    logic [7:0] tg;
    logic       flt;
    logic       clr;
    int         cyc;
    out_t       exp;
  } vec_t;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] target_duty = 8'd0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] duty_cycle;
  logic       pwm_reset;
  logic       running;
  logic       fault_latched;
  logic [2:0] state;

  int   n_chk = 0;
  int   n_fail = 0;
  out_t sb[$];
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  pwm_softstart_ctrl #(
    .RAMP_DIV  (4),
    .RAMP_STEP (16),
    .MAX_DUTY  (240)
  ) dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .enable        (enable),
    .target_duty   (target_duty),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .duty_cycle    (duty_cycle),
    .pwm_reset     (pwm_reset),
    .running       (running),
    .fault_latched (fault_latched),
    .state         (state)
  );

  function automatic out_t o(
    input logic [7:0] d,
    input logic pr, rn, fl,
    input logic [2:0] st
  );
    out_t r;
    r.duty = d;
    r.pr   = pr;
    r.rn   = rn;
    r.fl   = fl;
    r.st   = st;
    return r;
  endfunction

  function automatic void add(
    input string nm,
    input logic en,
    input logic [7:0] tg,
    input int cyc,
    input out_t e
  );
    vec_t v;
    v.nm  = nm;
    v.en  = en;
    v.tg  = tg;
    v.flt = 1'b0;
    v.clr = 1'b0;
    v.cyc = cyc;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(
    input logic en,
    input logic [7:0] tg,
    input logic flt,
    input logic clr
  );
    enable      = en;
    target_duty = tg;
    fault       = flt;
    fault_clr   = clr;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm);
    out_t act;
    out_t exp;
    act.duty = duty_cycle;
    act.pr   = pwm_reset;
    act.rn   = running;
    act.fl   = fault_latched;
    act.st   = state;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued", nm);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got duty=%0d rst=%0b run=%0b flt=%0b st=%0d, want duty=%0d rst=%0b run=%0b flt=%0b st=%0d",
                 nm, act.duty, act.pr, act.rn, act.fl, act.st,
                 exp.duty, exp.pr, exp.rn, exp.fl, exp.st);
      end
    end
  endtask

  initial begin
    add("ss_entry",    1, 100,  1, o(  0, 0, 0, 0, 1));
    add("ss_16",       1, 100,  4, o( 16, 0, 0, 0, 1));
    add("ss_32",       1, 100,  4, o( 32, 0, 0, 0, 1));
    add("ss_96",       1, 100, 16, o( 96, 0, 0, 0, 1));
    add("ss_100",      1, 100,  4, o(100, 0, 0, 0, 1));
    add("ss_run",      1, 100,  1, o(100, 0, 1, 0, 2));
    add("ss_hold",     1, 100,  8, o(100, 0, 1, 0, 2));
    add("clamp_116",   1, 255,  3, o(116, 0, 1, 0, 2));
    add("clamp_228",   1, 255, 28, o(228, 0, 1, 0, 2));
    add("clamp_240",   1, 255,  4, o(240, 0, 1, 0, 2));
    add("clamp_hold",  1, 255, 12, o(240, 0, 1, 0, 2));
    add("track_224",   1, 100,  4, o(224, 0, 1, 0, 2));
    add("track_100",   1, 100, 32, o(100, 0, 1, 0, 2));
    add("track_hold",  1, 100,  4, o(100, 0, 1, 0, 2));
    add("stop_entry",  0, 100,  1, o(100, 0, 0, 0, 3));
    add("stop_84",     0, 100,  4, o( 84, 0, 0, 0, 3));
    add("stop_52",     0, 100,  8, o( 52, 0, 0, 0, 3));
    add("reup_entry",  1, 100,  1, o( 52, 0, 0, 0, 1));
    add("reup_68",     1, 100,  4, o( 68, 0, 0, 0, 1));
    add("reup_100",    1, 100,  8, o(100, 0, 0, 0, 1));
    add("reup_run",    1, 100,  1, o(100, 0, 1, 0, 2));
    add("down_entry",  0, 100,  1, o(100, 0, 0, 0, 3));
    add("down_4",      0, 100, 24, o(  4, 0, 0, 0, 3));
    add("down_0",      0, 100,  4, o(  0, 0, 0, 0, 3));
    add("down_idle",   0, 100,  1, o(  0, 1, 0, 0, 0));
    add("zero_ramp",   1,   0,  1, o(  0, 0, 0, 0, 1));
    add("zero_run",    1,   0,  1, o(  0, 0, 1, 0, 2));
    add("zero_down",   0,   0,  1, o(  0, 0, 0, 0, 3));
    add("zero_idle",   0,   0,  1, o(  0, 1, 0, 0, 0));

    #22;
    sb.push_back(o(0, 1, 0, 0, 0));
    check("reset_state");
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].tg, tbl[i].flt, tbl[i].clr);
      sb.push_back(tbl[i].exp);
      cycles(tbl[i].cyc);
      check(tbl[i].nm);
    end

    drive(1, 100, 0, 0);
    sb.push_back(o(0, 0, 0, 0, 1));
    cycles(1);
    check("flt_ramp");
    sb.push_back(o(16, 0, 0, 0, 1));
    cycles(4);
    check("flt_ramp_16");
    drive(1, 100, 1, 0);
    sb.push_back(o(0, 1, 0, 1, 4));
    cycles(1);
    check("flt_entry");
    drive(1, 100, 1, 1);
    sb.push_back(o(0, 1, 0, 1, 4));
    cycles(1);
    check("flt_clr_blocked");
    drive(1, 100, 0, 0);
    sb.push_back(o(0, 1, 0, 1, 4));
    cycles(3);
    check("flt_hold");
    drive(1, 100, 0, 1);
    sb.push_back(o(0, 1, 0, 0, 0));
    cycles(1);
    check("flt_clear");
    drive(1, 100, 0, 0);
    sb.push_back(o(0, 0, 0, 0, 1));
    cycles(1);
    check("flt_restart");

    drive(1, 20, 0, 0);
    sb.push_back(o(20, 0, 1, 0, 2));
    cycles(10);
    check("rst_pre_run");
    #3;
    reset_n = 1'b0;
    #1;
    sb.push_back(o(0, 1, 0, 0, 0));
    check("rst_async");
    drive(0, 20, 0, 0);
    #2;
    reset_n = 1'b1;
    sb.push_back(o(0, 1, 0, 0, 0));
    cycles(2);
    check("rst_idle");
    drive(1, 20, 0, 0);
    sb.push_back(o(0, 0, 0, 0, 1));
    cycles(1);
    check("rst_restart");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_softstart_ctrl.md
Name: pwm_softstart_ctrl

Overview:
- Sequences the 8-bit PWM generator in the SMPS ZVS power stage.
- Drives the generator's DUTY_CYCLE and reset inputs.
- Provides soft-start, slew-limited duty tracking, controlled ramp-down on disable, and immediate latched shutdown on fault.
- Sits between the regulation/command logic (target duty, enable, fault) and the PWM generator.

Parameters:
- RAMP_DIV, 256, number of CLK cycles between duty updates (ramp tick period); legal range 1..65535.
- RAMP_STEP, 1, duty LSBs added or subtracted per ramp tick; legal range 1..255.
- MAX_DUTY, 240, upper clamp on the commanded duty, which preserves ZVS dead-time margin.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 requests converter running, 0 requests controlled shutdown.
- target_duty  input  8  requested steady-state duty; clamped to MAX_DUTY internally.
- fault  input  1  level, synchronous to CLK; overcurrent/overvoltage indication.
- fault_clr  input  1  single-cycle pulse; clears the latched fault.
- duty_cycle  output  8  registered duty to the PWM generator.
- pwm_reset  output  1  registered; 1 holds the PWM generator output low.
- running  output  1  registered; 1 when the state is RUN.
- fault_latched  output  1  registered; 1 when the state is FAULT.
- state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State is IDLE; duty_cycle=0, pwm_reset=1, running=0, fault_latched=0.
  - The ramp tick counter is 0.
- Clamped target: tgt = min(target_duty, MAX_DUTY).
- Ramp tick:
  - A 16-bit counter counts 0..RAMP_DIV-1, then wraps; tick=1 on the wrap cycle.
  - The counter is cleared on every entry to RAMP_UP and RAMP_DOWN, so the first step occurs RAMP_DIV cycles after entry.
- Saturating step, evaluated on tick only, using 9-bit intermediates with no wrap:
  - up: duty = (tgt - duty <= RAMP_STEP) ? tgt : duty + RAMP_STEP.
  - down: duty = (duty <= RAMP_STEP) ? 0 : duty - RAMP_STEP.
- States and transitions:
  - IDLE (0):
    - duty=0, pwm_reset=1.
    - enable=1 and fault=0 -> RAMP_UP; pwm_reset drops to 0 on the next cycle.
  - RAMP_UP (1):
    - Steps toward tgt on each tick.
    - duty==tgt -> RUN.
    - enable=0 -> RAMP_DOWN.
  - RUN (2):
    - Slew-limited tracking: on tick, steps up or down toward tgt; no change when equal.
    - enable=0 -> RAMP_DOWN.
  - RAMP_DOWN (3):
    - Steps down on tick; pwm_reset stays 0.
    - duty==0 -> IDLE, with pwm_reset=1 one cycle later.
    - enable=1 again -> RAMP_UP from the current duty, with no reset to 0.
  - FAULT (4):
    - Entry: duty=0 and pwm_reset=1 in the cycle after fault is sampled high.
    - Exit to IDLE only on fault_clr=1 while fault=0; fault_clr with fault=1 is ignored.
    - enable is ignored while in FAULT.
- fault priority: fault=1 in any state other than FAULT goes to FAULT next cycle, overriding enable and ramp logic. This is a one-cycle latency from fault to zero duty.
- Simultaneous events:
  - enable falling on the same cycle as reaching tgt -> RAMP_DOWN.
  - tgt=0 with enable=1 -> RAMP_UP immediately satisfies duty==tgt -> RUN with duty 0 and pwm_reset=0.
- The target may change at any time; duty never changes by more than RAMP_STEP per tick.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: PWM_SOFTSTART_AUTO_RETRY_EN.
- With the macro defined:
  - FAULT additionally runs a 24-bit cooldown counter of fixed 2^20 cycles, counted while fault=0 and restarted on any fault=1.
  - On expiry, the FSM goes to IDLE automatically; a new soft-start follows if enable=1.
  - fault_clr still works as an early exit.
- Without the macro: FAULT exits only via fault_clr; no counter logic is synthesized.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - the state encodings: ST_IDLE=0, ST_RAMP_UP=1, ST_RUN=2, ST_RAMP_DOWN=3, ST_FAULT=4;
  - DUTY_W=8;
  - the cooldown length constant.
- One sub-module, ramp_tick_gen: parameterized prescaler with sync clear, outputting a single-cycle tick.

Test Plan:
- Soft-start: RAMP_DIV=4, RAMP_STEP=16, tgt=100, enable=1 -> duty goes 16, 32 … 96, 100 at 4-cycle spacing, then running=1 with duty held at 100.
- Clamp/slew: in RUN, target_duty 100 -> 255 with MAX_DUTY=240 -> duty climbs by 16 per tick and saturates at exactly 240, never exceeding it.
- Controlled stop: in RUN at 100, enable=0 -> RAMP_DOWN 84 … 4, 0, then IDLE with pwm_reset=1 the cycle after duty hits 0. Re-asserting enable at duty 52 -> ramps up from 52.
- Fault: fault pulse during RAMP_UP -> next cycle duty=0, pwm_reset=1, fault_latched=1. fault_clr while fault=1 -> stays FAULT. fault_clr after fault=0 -> IDLE, then restart.
- Async reset: drop reset_n mid-RUN, asynchronous to CLK -> outputs reach reset values immediately, without waiting for a clock edge. Release -> IDLE.
- With PWM_SOFTSTART_AUTO_RETRY_EN defined: after fault clears, 2^20 cycles later the FSM auto-returns to IDLE and RAMP_UP with enable=1. A fault re-pulse mid-cooldown restarts the count.
